// File: rtl/prim_fifo_n.sv
// prim_fifo_n: synchronous FIFO with registered upstream ready, downstream stall,
// flush, occupancy count and an almost-full flag. Works for any DEPTH >= 2,
// including non-power-of-two depths.
//
// Ports:
//   clk       sole clock, rising edge
//   reset     synchronous, active-high reset (control state only)
//   urdy_o    upstream ready, registered: high while occupancy < DEPTH
//   uvld_i    upstream valid
//   udat_i    upstream payload
//   dstall_i  downstream stall, masks dvld_o and so blocks every downstream beat
//   drdy_i    downstream ready
//   dvld_o    downstream valid: occupancy != 0 and not stalled
//   ddat_o    head (oldest) entry
//   flush_i   discard all stored entries on the next edge
//   count_o   current occupancy
//   afull_o   registered flag, high while count_o >= AFULL_LEVEL
module prim_fifo_n #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       urdy_o,
  input  logic                       uvld_i,
  input  logic [WIDTH-1:0]           udat_i,
  input  logic                       dstall_i,
  input  logic                       drdy_i,
  output logic                       dvld_o,
  output logic [WIDTH-1:0]           ddat_o,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       afull_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, count_nxt;
  logic             urdy_q, afull_q;
  logic             ubeat, dbeat;

  // Explicit wrap so non-power-of-two depths never address past the last slot.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  assign ubeat   = urdy_q & uvld_i;
  assign dvld_o  = (count_q != '0) & ~dstall_i;
  assign dbeat   = dvld_o & drdy_i;
  assign ddat_o  = mem[rd_ptr];
  assign urdy_o  = urdy_q;
  assign afull_o = afull_q;
  assign count_o = count_q;

  always_comb begin
    count_nxt = count_q;
    if (flush_i) begin
      count_nxt = '0;
    end else if (ubeat && !dbeat) begin
      count_nxt = count_q + CW'(1);
    end else if (dbeat && !ubeat) begin
      count_nxt = count_q - CW'(1);
    end
  end

  // Control stage: ready and almost-full are derived from the next occupancy so
  // they are registered yet always agree with count_o. A dbeat while full
  // therefore frees the slot only in the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      urdy_q  <= 1'b1;
      afull_q <= 1'b0;
    end else begin
      count_q <= count_nxt;
      urdy_q  <= (count_nxt < DEPTH_C);
      afull_q <= (count_nxt >= AFULL_C);
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (ubeat) wr_ptr <= ptr_inc(wr_ptr);
        if (dbeat) rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

  // Data stage: storage is not reset; stale slots are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (ubeat) mem[wr_ptr] <= udat_i;
  end

endmodule
